// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter sharing one non-pipelined AES-128 core between two requesters.
// Each grant pulses the core enable once, waits for the core's valid (or a timeout), then returns a tagged response.
module aes_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic [127:0] core_data_in,
  output logic [127:0] core_key,
  output logic         core_enable,
  input  logic [127:0] core_data_out,
  input  logic         core_data_out_vld,
  output logic         busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic             sel;
  logic             hs;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
      sel = ~last_grant;
    end else if (req1_valid) begin
      sel = 1'b1;
    end else begin
      sel = 1'b0;
    end
  end

  // Readies are gated by reset so every output reads 0 while reset is held.
  assign req0_ready = RST && (state == IDLE) && req0_valid && (sel == 1'b0);
  assign req1_ready = RST && (state == IDLE) && req1_valid && (sel == 1'b1);
  assign hs         = req0_ready || req1_ready;

  // Next-state decode; a core valid beats a timeout landing in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (hs) next_state = ISSUE;
        else    next_state = IDLE;
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (core_data_out_vld || (cnt == TMO_LAST)) next_state = RESP;
        else                                        next_state = WAIT;
      end
      RESP: begin
        if (rsp_ready) next_state = IDLE;
        else           next_state = RESP;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register plus registered datapath and outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      cnt          <= '0;
      core_data_in <= 128'd0;
      core_key     <= 128'd0;
      core_enable  <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= 128'd0;
      rsp_id       <= 1'b0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state       <= next_state;
      core_enable <= (state == IDLE) && hs;
      rsp_valid   <= (next_state == RESP);
      busy        <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (hs) begin
            core_data_in <= sel ? req1_data : req0_data;
            core_key     <= sel ? req1_key  : req0_key;
            rsp_id       <= sel;
            last_grant   <= sel;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (core_data_out_vld) begin
            rsp_data <= core_data_out;
            rsp_err  <= 1'b0;
          end else if (cnt == TMO_LAST) begin
            rsp_data <= 128'd0;
            rsp_err  <= 1'b1;
          end
        end
        RESP: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter with a latency-programmable AES core stand-in.
module tb_aes_req_arbiter;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         CLK, RST;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_data, req0_key, req1_data, req1_key;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [127:0] rsp_data, core_data_in, core_key, core_data_out;
  logic         core_enable, core_data_out_vld, busy;

  int   lat;
  logic hang;
  logic spur_vld;
  logic model_vld;
  int   mcnt;
  int   checks;
  int   failures;

  typedef struct {
    logic         v0;
    logic         v1;
    logic [127:0] d0;
    logic [127:0] k0;
    logic [127:0] d1;
    logic [127:0] k1;
    logic         id;
  } vec_t;

  vec_t vecs [7];

  aes_req_arbiter #(.TIMEOUT_CYCLES(64)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .core_data_in(core_data_in), .core_key(core_key), .core_enable(core_enable),
    .core_data_out(core_data_out), .core_data_out_vld(core_data_out_vld), .busy(busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Core stand-in: valid pulses lat cycles after the enable cycle; known vector returns FIPS-197 ciphertext.
  always @(negedge CLK or negedge RST) begin
    if (!RST) begin
      mcnt          <= 0;
      model_vld     <= 1'b0;
      core_data_out <= 128'd0;
    end else begin
      model_vld <= (mcnt == 1);
      if (core_enable && !hang) begin
        mcnt          <= lat;
        core_data_out <= (core_data_in == FIPS_PT && core_key == FIPS_KEY) ? FIPS_CT
                                                                          : (core_data_in ^ core_key);
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
      end
    end
  end

  assign core_data_out_vld = model_vld | spur_vld;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present a request, check the grant, then follow it until rsp_valid (left pending for the caller).
  task automatic run_txn(input logic v0, input logic v1,
                         input logic [127:0] d0, input logic [127:0] k0,
                         input logic [127:0] d1, input logic [127:0] k1,
                         input logic exp_id, input int exp_lat,
                         input logic [127:0] exp_data, input logic exp_err);
    int n;
    int pulses;
    int en_at;
    req0_valid = v0; req0_data = d0; req0_key = k0;
    req1_valid = v1; req1_data = d1; req1_key = k1;
    #1;
    check1("busy_before", busy, 1'b0);
    check1("req0_ready", req0_ready, exp_id == 1'b0);
    check1("req1_ready", req1_ready, exp_id == 1'b1);
    tick();
    n = 1; pulses = 0; en_at = 0;
    if (core_enable) begin pulses++; en_at = n; end
    check128("core_data_in", core_data_in, exp_id ? d1 : d0);
    check128("core_key", core_key, exp_id ? k1 : k0);
    check1("busy_issue", busy, 1'b1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    while (!rsp_valid && n < 300) begin
      tick();
      n++;
      if (core_enable) pulses++;
    end
    checki("enable_at", en_at, 1);
    checki("enable_pulses", pulses, 1);
    checki("rsp_latency", n, exp_lat);
    check128("rsp_data", rsp_data, exp_data);
    check1("rsp_id", rsp_id, exp_id);
    check1("rsp_err", rsp_err, exp_err);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    check1("rsp_valid_drop", rsp_valid, 1'b0);
    check1("busy_idle", busy, 1'b0);
  endtask

  initial begin
    logic [127:0] exp_d;
    logic [127:0] hold_d;
    int           n;
    checks = 0; failures = 0;
    lat = 10; hang = 1'b0; spur_vld = 1'b0;
    RST = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 128'd0; req0_key = 128'd0; req1_data = 128'd0; req1_key = 128'd0;

    // Table: tie pattern alternates from last_grant=0 (after the FIPS block), then lone requesters.
    for (int i = 0; i < 7; i++) begin
      vecs[i].d0 = {4{32'hA000_0000 | 32'(i)}};
      vecs[i].k0 = {4{32'h0F0F_0000 | 32'(i)}};
      vecs[i].d1 = {4{32'hB000_0000 | 32'(i)}};
      vecs[i].k1 = {4{32'h00F0_1000 | 32'(i)}};
    end
    vecs[0].v0 = 1'b1; vecs[0].v1 = 1'b1; vecs[0].id = 1'b1;
    vecs[1].v0 = 1'b1; vecs[1].v1 = 1'b1; vecs[1].id = 1'b0;
    vecs[2].v0 = 1'b1; vecs[2].v1 = 1'b1; vecs[2].id = 1'b1;
    vecs[3].v0 = 1'b1; vecs[3].v1 = 1'b1; vecs[3].id = 1'b0;
    vecs[4].v0 = 1'b1; vecs[4].v1 = 1'b0; vecs[4].id = 1'b0;
    vecs[5].v0 = 1'b0; vecs[5].v1 = 1'b1; vecs[5].id = 1'b1;
    vecs[6].v0 = 1'b1; vecs[6].v1 = 1'b1; vecs[6].id = 1'b0;

    // Reset state, with both requesters pushing.
    #12;
    check1("rst_req0_ready", req0_ready, 1'b0);
    check1("rst_req1_ready", req1_ready, 1'b0);
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    check1("rst_core_enable", core_enable, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check128("rst_core_data_in", core_data_in, 128'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    RST = 1'b1;
    tick();

    // FIPS-197 vector, L=10: rsp_valid 12 cycles after the handshake.
    run_txn(1'b1, 1'b0, FIPS_PT, FIPS_KEY, 128'd0, 128'd0, 1'b0, 12, FIPS_CT, 1'b0);
    finish_rsp();

    // Table-driven grants at L=1 (3-cycle latency).
    lat = 1;
    for (int i = 0; i < 7; i++) begin
      exp_d = vecs[i].id ? (vecs[i].d1 ^ vecs[i].k1) : (vecs[i].d0 ^ vecs[i].k0);
      run_txn(vecs[i].v0, vecs[i].v1, vecs[i].d0, vecs[i].k0, vecs[i].d1, vecs[i].k1,
              vecs[i].id, 3, exp_d, 1'b0);
      finish_rsp();
    end

    // Hung core: response 66 cycles after handshake (65 after enable), error set, data zero.
    hang = 1'b1;
    run_txn(1'b1, 1'b0, 128'h1111, 128'h2222, 128'd0, 128'd0, 1'b0, 66, 128'd0, 1'b1);
    finish_rsp();
    hang = 1'b0;
    run_txn(1'b0, 1'b1, 128'd0, 128'd0, 128'h3333, 128'h4444, 1'b1, 3, 128'h3333 ^ 128'h4444, 1'b0);
    finish_rsp();

    // Back-pressure: response held 20 cycles while req1 waits.
    rsp_ready = 1'b0;
    hold_d = 128'hDEAD_0000 ^ 128'h0000_BEEF;
    run_txn(1'b1, 1'b0, 128'hDEAD_0000, 128'h0000_BEEF, 128'd0, 128'd0, 1'b0, 3, hold_d, 1'b0);
    req1_valid = 1'b1; req1_data = 128'h5555; req1_key = 128'h6666;
    for (int i = 0; i < 20; i++) begin
      #1;
      check1("hold_rsp_valid", rsp_valid, 1'b1);
      check128("hold_rsp_data", rsp_data, hold_d);
      check1("hold_rsp_id", rsp_id, 1'b0);
      check1("hold_req1_ready", req1_ready, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check1("after_rsp_req1_ready", req1_ready, 1'b1);
    run_txn(1'b0, 1'b1, 128'd0, 128'd0, 128'h5555, 128'h6666, 1'b1, 3, 128'h5555 ^ 128'h6666, 1'b0);
    finish_rsp();

    // Spurious valids in IDLE and in ISSUE are ignored.
    spur_vld = 1'b1;
    tick();
    spur_vld = 1'b0;
    check1("spur_idle_rsp_valid", rsp_valid, 1'b0);
    check1("spur_idle_busy", busy, 1'b0);
    lat = 3;
    req0_valid = 1'b1; req0_data = 128'h7777; req0_key = 128'h8888;
    #1;
    check1("spur_req0_ready", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    check1("spur_enable", core_enable, 1'b1);
    spur_vld = 1'b1;
    tick();
    spur_vld = 1'b0;
    check1("spur_issue_rsp_valid", rsp_valid, 1'b0);
    n = 2;
    while (!rsp_valid && n < 300) begin
      tick();
      n++;
    end
    checki("spur_latency", n, 5);
    check128("spur_rsp_data", rsp_data, 128'h7777 ^ 128'h8888);
    finish_rsp();

    // Reset mid-WAIT: everything drops at once, then a tie goes to req0 with no stale response.
    hang = 1'b1;
    req1_valid = 1'b1; req1_data = 128'h9999; req1_key = 128'hAAAA;
    tick();
    req1_valid = 1'b0;
    tick(); tick(); tick();
    check1("midwait_busy", busy, 1'b1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    RST = 1'b0;
    #1;
    check1("arst_busy", busy, 1'b0);
    check1("arst_rsp_valid", rsp_valid, 1'b0);
    check1("arst_core_enable", core_enable, 1'b0);
    check1("arst_req0_ready", req0_ready, 1'b0);
    check1("arst_req1_ready", req1_ready, 1'b0);
    check128("arst_core_data_in", core_data_in, 128'd0);
    check128("arst_core_key", core_key, 128'd0);
    check1("arst_rsp_id", rsp_id, 1'b0);
    tick();
    RST = 1'b1;
    hang = 1'b0;
    lat = 1;
    run_txn(1'b1, 1'b1, 128'hC0DE, 128'hF00D, 128'h9999, 128'hAAAA, 1'b0, 3, 128'hC0DE ^ 128'hF00D, 1'b0);
    finish_rsp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_req_arbiter.md
Name: aes_req_arbiter

Overview:
- Shares one non-pipelined AES-128 encryption core between two requesters.
- Round-robin arbitration; each grant is sequenced as a one-cycle core Enable pulse, then a wait for the core's Data_Out_VLD.
- Returns the ciphertext with a requester tag, or flags a timeout error.
- Sits between the two block-level clients and the AES-128 core; drives the core's Data_In, Key and Enable inputs.

Parameters:
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before the core is declared hung (range 1..1023).
- CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the wait counter (derived; not overridden).

Ports:
CLK  in  1  system clock, all logic on posedge
RST  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 has a block
req0_ready  out  1  requester 0 handshake accept
req0_data  in  128  requester 0 plaintext
req0_key  in  128  requester 0 key
req1_valid  in  1  requester 1 has a block
req1_ready  out  1  requester 1 handshake accept
req1_data  in  128  requester 1 plaintext
req1_key  in  128  requester 1 key
rsp_valid  out  1  result available
rsp_ready  in  1  result consumer accept
rsp_data  out  128  ciphertext (0 on error)
rsp_id  out  1  requester index of the result
rsp_err  out  1  1 = core timeout
core_data_in  out  128  to core Data_In
core_key  out  128  to core Key
core_enable  out  1  to core Enable, one-cycle pulse
core_data_out  in  128  from core Data_Out
core_data_out_vld  in  1  from core Data_Out_VLD, one-cycle pulse
busy  out  1  state != IDLE

Behaviour:
Reset (RST low, async)
- state=IDLE; all outputs 0; counter=0.
- last_grant=1, so requester 0 wins the first tie.
- Reset in any state aborts the transaction; no response is produced.

FSM states: IDLE, ISSUE, WAIT, RESP

IDLE
- sel = the single valid requester; if both are valid, sel = !last_grant.
- reqN_ready = (state==IDLE) && valid && sel==N. This is combinational; at most one ready is high.
- On handshake: register data/key into core_data_in/core_key, rsp_id<=sel, last_grant<=sel, go to ISSUE.
- A requester that drops valid before its handshake is simply not granted; no state change.

ISSUE
- core_enable=1 for exactly this cycle (registered output). Counter cleared. Go to WAIT.
- core_data_out_vld in this cycle is ignored.

WAIT
- Counter increments each cycle.
- On core_data_out_vld: rsp_data<=core_data_out, rsp_err<=0, go to RESP.
- Otherwise, when counter==TIMEOUT_CYCLES-1: rsp_data<=0, rsp_err<=1, go to RESP.
- If vld and timeout occur in the same cycle, vld wins (err=0).

RESP
- rsp_valid=1. rsp_data, rsp_id and rsp_err are held stable until rsp_ready.
- On rsp_valid&&rsp_ready: go to IDLE.
- core_data_out_vld pulses in IDLE or RESP are ignored and counted in no way.

Other rules
- core_data_in/core_key are held from the handshake until the next handshake; they never change during ISSUE or WAIT.
- Timing: handshake at cycle T, core_enable at T+1, core vld at T+1+L (L>=1), rsp_valid at T+2+L.
- Minimum handshake-to-handshake spacing is 4 cycles (L=1, rsp_ready tied high).
- Only one transaction is in flight; no buffering of a second request.

Test Plan:
- Reset, core model L=10, req0 key=000102030405060708090a0b0c0d0e0f, data=00112233445566778899aabbccddeeff -> req0_ready at T, core_enable pulse at T+1 only, rsp_valid at T+12 with rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id=0, rsp_err=0.
- req0 and req1 held valid continuously for 4 blocks, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; no two readys high in one cycle.
- Core never asserts vld, TIMEOUT_CYCLES=64 -> rsp_valid 65 cycles after core_enable, rsp_err=1, rsp_data=0; next request proceeds normally.
- rsp_ready held low 20 cycles while req1 is valid -> rsp_valid, rsp_data and rsp_id stable; req1_ready stays 0; req1 is granted the cycle after the rsp handshake.
- Spurious core_data_out_vld during IDLE and during ISSUE -> no rsp_valid; the subsequent real vld is captured correctly.
- RST asserted mid-WAIT -> all outputs 0 asynchronously; after release, a tie grants req0 and no stale response appears.
